// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller for the HI/LO register pair.
// Shift-add multiply and restoring divide on magnitudes, then a sign fix-up and a one-cycle write-back.
//
// state | meaning
// IDLE  | waiting for Start with a valid Op
// MUL   | shift-add iterations, SIZE cycles
// DIV   | restoring-division iterations, SIZE cycles
// FIX   | two's-complement sign correction for signed ops
// WB    | Done pulse with exactly one HI/LO write enable
module mdu_ctrl #(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [SIZE-1:0] SrcA,
  input  logic [SIZE-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic            DivZero,
  output logic            HLEN,
  output logic            HEN,
  output logic            LEN,
  output logic [SIZE-1:0] ALUResult_1,
  output logic [SIZE-1:0] ALUResult_2
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              sign_a, sign_b, div_zero_q;
  logic [SIZE-1:0]   mag_a, mag_b, data_q;
  logic [2*SIZE-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              start_ok, is_mul, is_div, sa_in, sb_in, b_zero;
  logic [SIZE-1:0]   mag_a_in, mag_b_in;
  logic [SIZE:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [SIZE-1:0]   div_rem, acc_hi, acc_lo, fix_hi, fix_lo;
  logic [2*SIZE-1:0] fix_prod;

  assign start_ok = Start && (Op[2:1] != 2'b11);
  assign is_mul   = (Op[2:1] == 2'b00);
  assign is_div   = (Op[2:1] == 2'b01);
  assign b_zero   = (SrcB == '0);
  // Sign bits only matter for MULT/DIV; unsigned and move ops latch them as 0.
  assign sa_in    = ~Op[2] & ~Op[0] & SrcA[SIZE-1];
  assign sb_in    = ~Op[2] & ~Op[0] & SrcB[SIZE-1];
  assign mag_a_in = sa_in ? (~SrcA + 1'b1) : SrcA;
  assign mag_b_in = sb_in ? (~SrcB + 1'b1) : SrcB;

  assign acc_hi    = acc[2*SIZE-1:SIZE];
  assign acc_lo    = acc[SIZE-1:0];
  assign mul_sum   = {1'b0, acc_hi} + (acc[0] ? {1'b0, mag_a} : '0);
  assign div_shift = {acc_hi, acc[SIZE-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_rem   = div_ge ? SIZE'(div_shift - {1'b0, mag_b}) : div_shift[SIZE-1:0];
  assign fix_hi    = sign_a ? (~acc_hi + 1'b1) : acc_hi;
  assign fix_lo    = (sign_a ^ sign_b) ? (~acc_lo + 1'b1) : acc_lo;
  assign fix_prod  = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    Busy        = (state != S_IDLE);
    Done        = 1'b0;
    DivZero     = 1'b0;
    HLEN        = 1'b0;
    HEN         = 1'b0;
    LEN         = 1'b0;
    ALUResult_1 = '0;
    ALUResult_2 = '0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (is_mul)      state_nxt = S_MUL;
          else if (is_div) state_nxt = b_zero ? S_WB : S_DIV;
          else             state_nxt = S_WB;
        end
      end
      S_MUL: if (cnt == '0) state_nxt = S_FIX;
      S_DIV: if (cnt == '0) state_nxt = S_FIX;
      S_FIX: state_nxt = S_WB;
      S_WB: begin
        state_nxt = S_IDLE;
        Done      = 1'b1;
        if (op_q[2]) begin
          HEN         = ~op_q[0];
          LEN         = op_q[0];
          ALUResult_1 = data_q;
        end else begin
          HLEN    = 1'b1;
          DivZero = div_zero_q;
          if (div_zero_q) begin
            ALUResult_1 = data_q;
            ALUResult_2 = '1;
          end else begin
            ALUResult_1 = acc_hi;
            ALUResult_2 = acc_lo;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q       <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      div_zero_q <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      data_q     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            op_q       <= Op;
            sign_a     <= sa_in;
            sign_b     <= sb_in;
            div_zero_q <= is_div & b_zero;
            mag_a      <= mag_a_in;
            mag_b      <= mag_b_in;
            data_q     <= SrcA;
            cnt        <= CNT_LOAD;
            acc        <= {{SIZE{1'b0}}, (is_mul ? mag_b_in : mag_a_in)};
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[SIZE-1:1]};
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          acc <= {div_rem, acc[SIZE-2:0], div_ge};
          cnt <= cnt - 1'b1;
        end
        // Remainder follows the dividend sign; quotient and product follow sA^sB.
        S_FIX: acc <= op_q[1] ? {fix_hi, fix_lo} : fix_prod;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mdu_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        Busy, Done, DivZero, HLEN, HEN, LEN;
  logic [31:0] ALUResult_1, ALUResult_2;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.SIZE(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HLEN(HLEN), .HEN(HEN), .LEN(LEN),
    .ALUResult_1(ALUResult_1), .ALUResult_2(ALUResult_2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit / native division arithmetic on the operation meaning.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output logic hl, output logic he, output logic le);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    hi = '0; lo = '0; dz = 1'b0; hl = 1'b0; he = 1'b0; le = 1'b0;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; hl = 1'b1; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; hl = 1'b1; end
      3'd2, 3'd3: begin
        hl = 1'b1;
        if (b == 0) begin dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; end
        else if (op == 3'd3) begin lo = a / b; hi = a % b; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); lo = q; hi = r; end
      end
      3'd4: begin he = 1'b1; hi = a; end
      3'd5: begin le = 1'b1; hi = a; end
      default: ;
    endcase
  endfunction

  // Issue one op and follow it to write-back; poke>0 re-pulses Start (DIVU) at that cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [31:0] ehi, elo;
    logic        edz, ehl, ehe, ele;
    int          lat, n;
    bit          busy_ok, quiet;
    model(op, a, b, ehi, elo, edz, ehl, ehe, ele);
    lat = (op[2] || (op[1] && b == 0)) ? 1 : 34;
    @(negedge CLK);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    @(negedge CLK);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    n = 1; busy_ok = Busy; quiet = 1'b1;
    while (!Done && n < 100) begin
      quiet &= !(HLEN | HEN | LEN | DivZero) && ALUResult_1 == 0 && ALUResult_2 == 0;
      if (n == poke) begin Start = 1'b1; Op = 3'b011; SrcA = $urandom; SrcB = $urandom; end
      else Start = 1'b0;
      @(negedge CLK);
      n++;
      busy_ok &= Busy;
    end
    Start = 1'b0;
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy"}, busy_ok, 1);
    chk({tag, ".quiet"}, quiet, 1);
    chk({tag, ".en"}, {HLEN, HEN, LEN, DivZero}, {ehl, ehe, ele, edz});
    chk({tag, ".r1"}, ALUResult_1, ehi);
    if (ehl) chk({tag, ".r2"}, ALUResult_2, elo);
    @(negedge CLK);
    chk({tag, ".after"}, {Busy, Done, HLEN, HEN, LEN}, 5'b0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    #2;
    chk("rst.out", {Busy, Done, DivZero, HLEN, HEN, LEN, ALUResult_1, ALUResult_2}, '0);
    @(negedge CLK); RST = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu",      3'd3, 32'd100, 32'd7, 0);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_z",    3'd3, 32'h1234, 32'd0, 0);
    run_op("div_z",     3'd2, 32'h8765_4321, 32'd0, 0);
    run_op("mthi",      3'd4, 32'hCAFE_F00D, 32'd0, 0);
    run_op("mtlo",      3'd5, 32'h5, 32'd0, 0);

    // Reserved op codes must leave the block idle.
    for (int k = 6; k < 8; k++) begin
      @(negedge CLK); Start = 1'b1; Op = 3'(k); SrcA = $urandom; SrcB = $urandom;
      @(negedge CLK); Start = 1'b0;
      chk("rsvd.idle", {Busy, Done, HLEN, HEN, LEN}, 5'b0);
      @(negedge CLK);
      chk("rsvd.idle2", {Busy, Done, HLEN, HEN, LEN}, 5'b0);
    end

    run_op("mult_poke", 3'd0, 32'h1234_5678, 32'hFEDC_BA98, 10);

    // Reset mid-multiply: outputs clear at once, no write-back afterwards.
    @(negedge CLK); Start = 1'b1; Op = 3'd0; SrcA = 32'h0BAD_F00D; SrcB = 32'h7;
    @(negedge CLK); Start = 1'b0;
    repeat (19) @(negedge CLK);
    chk("rst.busy_before", Busy, 1);
    RST = 1'b0;
    #1;
    chk("rst.mid", {Busy, Done, DivZero, HLEN, HEN, LEN, ALUResult_1, ALUResult_2}, '0);
    @(negedge CLK); RST = 1'b1;
    begin
      bit seen = 1'b0;
      repeat (40) begin
        @(negedge CLK);
        seen |= Busy | Done | HLEN | HEN | LEN;
      end
      chk("rst.no_pulse", seen, 0);
    end
    run_op("post_rst", 3'd3, 32'd1000, 32'd33, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 9 == 0) ra = 32'h8000_0000;
      if (i % 11 == 0) rb = 32'hFFFF_FFFF;
      run_op("rand", rop, ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller that computes the HI/LO results for MULT, MULTU, DIV and DIVU and handles MTHI/MTLO. It drives the write enables and write data of the HI/LO register pair: HLEN with ALUResult_1/ALUResult_2, or HEN/LEN with ALUResult_1. It sits between the main control FSM and the HI/LO register. The main FSM issues a one-cycle Start and stalls MFHI/MFLO while Busy is high.

## Interface

Parameters:
- SIZE, 32, operand and HI/LO width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Start  in  1  operation request; sampled only in IDLE.
- Op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- SrcA  in  SIZE  multiplicand, dividend, or MTHI/MTLO data.
- SrcB  in  SIZE  multiplier or divisor.
- Busy  out  1  high whenever state ≠ IDLE.
- Done  out  1  one-cycle pulse in the WB state.
- DivZero  out  1  high with Done when DIV/DIVU had SrcB == 0.
- HLEN  out  1  write both HI and LO.
- HEN  out  1  write HI only.
- LEN  out  1  write LO only.
- ALUResult_1  out  SIZE  HI data when HLEN is set; also the HEN/LEN data.
- ALUResult_2  out  SIZE  LO data when HLEN is set.

## Operation

States are IDLE, MUL, DIV, FIX and WB.

IDLE:
- On Start with a valid Op, latch Op, the operand magnitudes and the sign bits.
- Go to MUL (MULT/MULTU), DIV (DIV/DIVU) or WB (MTHI/MTLO).
- DIV/DIVU with SrcB == 0 goes directly to WB with the divide-by-zero flag set.
- Reserved Op, or Start deasserted: stay in IDLE, no effect.

MUL:
- Shift-add on unsigned magnitudes.
- 2·SIZE-bit accumulator; iteration counter of $clog2(SIZE)+1 bits.
- Exactly SIZE cycles, then go to FIX.

DIV:
- Restoring division on magnitudes, one quotient bit per cycle.
- Exactly SIZE cycles, then go to FIX.

FIX (one cycle):
- Signed ops apply sign correction by two's-complement negation.
- Product is negative iff sA^sB. Quotient is negative iff sA^sB. Remainder takes the sign of sA.
- Unsigned ops pass through unchanged.
- Then go to WB.

WB (one cycle):
- Assert Done and exactly one enable.
- MULT/DIV: HLEN = 1, ALUResult_1 = HI (product[2·SIZE-1:SIZE] or remainder), ALUResult_2 = LO (product[SIZE-1:0] or quotient).
- Divide by zero: HI = dividend (SrcA as latched), LO = all ones, DivZero = 1.
- MTHI: HEN = 1, ALUResult_1 = latched SrcA. MTLO: LEN = 1, ALUResult_1 = latched SrcA.
- Then go to IDLE.

Arithmetic rules:
- Signed overflow (most-negative / -1) is not trapped. It yields quotient = most-negative and remainder = 0, the natural wrap.
- Enables are mutually exclusive and are low in every state except WB.
- ALUResult_1/ALUResult_2 are 0 outside WB.

## Timing

- Reset: state IDLE. Busy, Done, DivZero, HLEN, HEN and LEN are 0; ALUResult_1 and ALUResult_2 are 0. All internal registers are cleared.
- Start accepted at edge t. Busy rises after t. WB is the cycle after edge t+L-1, and the HI/LO register captures at edge t+L.
- Latency L:
  - MUL/DIV: SIZE+2 (34 for SIZE=32).
  - Divide by zero: 1.
  - MTHI/MTLO: 1.
- Busy falls after the WB edge. A new Start is accepted on the first IDLE cycle after WB; there is no back-to-back issue in the WB cycle.
- Start while Busy: ignored. Operands are not relatched and the result is unaffected.
- SrcA/SrcB are needed only in the Start cycle.
- RST asserted mid-operation: immediate return to IDLE, all outputs 0, no enable pulse, and the partial result is discarded.
- The outputs are Moore, decoded from state and registers. They have no combinational path from Start/Op/SrcA/SrcB.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start at edge t -> WB/Done after edge t+33: HLEN = 1, ALUResult_1 = 0xFFFFFFFE, ALUResult_2 = 0x00000001. Busy high for exactly 34 cycles.
- MULT 0xFFFFFFFD (-3) × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV 0xFFFFFFF9 (-7) ÷ 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 ÷ 7 -> LO = 14, HI = 2. DIV 0x80000000 ÷ 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 0x1234 ÷ 0 -> WB one cycle after Start with DivZero = 1, HLEN = 1, HI = 0x1234, LO = 0xFFFFFFFF.
- MTHI 0xCAFEF00D -> one-cycle WB with HEN = 1, ALUResult_1 = 0xCAFEF00D, HLEN = LEN = 0. Then MTLO 0x5 -> LEN = 1 only. Op 110 -> no Busy, no enables.
- MULT started, second Start (DIVU) pulsed at iteration 10 -> ignored, MULT result unchanged. Separate run with RST low at iteration 20 -> all outputs 0 immediately, no HLEN pulse. Next Start after release completes normally.
